pcie2_x1_evt_stat: RTL and testbench

Event statistics stage sitting directly downstream of the x1 core's fast-to-slow pulse synchronizer, in the slow (`s_clk`) domain. Takes the synchronized per-bit event levels, detects rising edges, and accumulates them into per-bit saturating counters. Counters are read, and optionally cleared, through a single-cycle request/acknowledge port. A registered interrupt is raised while any counter is saturated.

---
 rtl/pcie2_x1_evt_pkg.sv | 18 +
 rtl/pcie2_x1_evt_ctr.sv | 38 +++
 rtl/pcie2_x1_evt_stat.sv | 94 +++++++++
 tb/tb_pcie2_x1_evt_stat.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie2_x1_evt_pkg.sv
// rtl/pcie2_x1_evt_pkg.sv - shared defaults and helpers for the event statistics stage
//
// Holds the default event/counter widths and a clog2 helper (minimum result 1)
// used to size the read-select field from the event width.
package pcie2_x1_evt_pkg;

  localparam int EVT_WIDTH_DEF = 4;
  localparam int EVT_CNT_W_DEF = 8;

  // Smallest w >= 1 with 2**w >= n; a 1-bit select is kept even for n <= 2.
  function automatic int evt_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pcie2_x1_evt_ctr.sv
// rtl/pcie2_x1_evt_ctr.sv - one saturating event counter with clear-plus-increment
//
// Ports:
//   s_clk - slow-domain clock
//   rst   - synchronous active-high reset
//   clr   - clear this counter this cycle
//   inc   - rising edge seen this cycle
//   cnt   - current count (saturates at all-ones, never wraps)
//   sat   - count is all-ones
module pcie2_x1_evt_ctr
  import pcie2_x1_evt_pkg::*;
#(
  parameter int CNT_W = EVT_CNT_W_DEF
) (
  input  logic             s_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign sat = &cnt;

  always_ff @(posedge s_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      // An event landing in the clear cycle becomes the first count.
      cnt <= inc ? CNT_ONE : '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pcie2_x1_evt_stat.sv
// rtl/pcie2_x1_evt_stat.sv - rising-edge event counters with read/clear port and saturation irq
//
// Ports:
//   s_clk     - slow-domain clock
//   rst       - synchronous active-high reset
//   evt_in    - synchronized event levels, one per bit
//   rd_req    - single-cycle read strobe; rd_sel/rd_clr sampled with it
//   rd_sel    - counter index (out-of-range reads return zero)
//   rd_clr    - clear the selected counter after reading it
//   rd_ack    - read response valid, one cycle after rd_req
//   rd_data   - counter value as it was in the request cycle
//   rd_sat    - selected counter was saturated in the request cycle
//   evt_pulse - registered one-cycle rising-edge pulses
//   irq       - registered OR of all saturation flags
module pcie2_x1_evt_stat
  import pcie2_x1_evt_pkg::*;
#(
  parameter int WIDTH = EVT_WIDTH_DEF,
  parameter int CNT_W = EVT_CNT_W_DEF,
  parameter int SEL_W = evt_clog2(WIDTH)
) (
  input  logic             s_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] evt_in,
  input  logic             rd_req,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             rd_clr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_sat,
  output logic [WIDTH-1:0] evt_pulse,
  output logic             irq
);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr_hit;
  logic [WIDTH-1:0] sat_vec;
  logic [CNT_W-1:0] cnt_arr [WIDTH];
  logic [CNT_W-1:0] sel_data;
  logic             sel_sat;

  assign rise = evt_in & ~prev;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ctr
    assign clr_hit[i] = rd_req & rd_clr & (rd_sel == SEL_W'(i));

    pcie2_x1_evt_ctr #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .s_clk (s_clk),
      .rst   (rst),
      .clr   (clr_hit[i]),
      .inc   (rise[i]),
      .cnt   (cnt_arr[i]),
      .sat   (sat_vec[i])
    );
  end

  // Select mux over the pre-update counter values; indices past WIDTH match
  // nothing and fall through to zero.
  always_comb begin
    sel_data = '0;
    sel_sat  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_data = cnt_arr[i];
        sel_sat  = sat_vec[i];
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (rst) begin
      prev      <= '0;
      evt_pulse <= '0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      rd_sat    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      prev      <= evt_in;
      evt_pulse <= rise;
      rd_ack    <= rd_req;
      irq       <= |sat_vec;
      // Response data holds between reads.
      if (rd_req) begin
        rd_data <= sel_data;
        rd_sat  <= sel_sat;
      end
    end
  end

endmodule

// File: tb/tb_pcie2_x1_evt_stat.sv
// tb/tb_pcie2_x1_evt_stat.sv - self-checking bench for pcie2_x1_evt_stat
//
// Three instances share one stimulus stream: default (4 bits, 8-bit counters),
// narrow counters (4 bits, 2-bit counters) and narrow width (3 bits, 8-bit).
module tb_pcie2_x1_evt_stat;

  logic       s_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] evt = '0;
  logic       rd_req = 1'b0;
  logic [1:0] rd_sel = '0;
  logic       rd_clr = 1'b0;

  logic       d0_ack, d1_ack, d2_ack;
  logic [7:0] d0_data, d2_data;
  logic [1:0] d1_data;
  logic       d0_sat, d1_sat, d2_sat;
  logic [3:0] d0_pulse, d1_pulse;
  logic [2:0] d2_pulse;
  logic       d0_irq, d1_irq, d2_irq;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 s_clk = ~s_clk;

  pcie2_x1_evt_stat #(.WIDTH(4), .CNT_W(8)) u_d0 (
    .s_clk(s_clk), .rst(rst), .evt_in(evt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_clr(rd_clr), .rd_ack(d0_ack), .rd_data(d0_data), .rd_sat(d0_sat),
    .evt_pulse(d0_pulse), .irq(d0_irq)
  );

  pcie2_x1_evt_stat #(.WIDTH(4), .CNT_W(2)) u_d1 (
    .s_clk(s_clk), .rst(rst), .evt_in(evt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_clr(rd_clr), .rd_ack(d1_ack), .rd_data(d1_data), .rd_sat(d1_sat),
    .evt_pulse(d1_pulse), .irq(d1_irq)
  );

  pcie2_x1_evt_stat #(.WIDTH(3), .CNT_W(8)) u_d2 (
    .s_clk(s_clk), .rst(rst), .evt_in(evt[2:0]), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_clr(rd_clr), .rd_ack(d2_ack), .rd_data(d2_data), .rd_sat(d2_sat),
    .evt_pulse(d2_pulse), .irq(d2_irq)
  );

  // Reference model: per-instance event counts as plain integers.
  int wid [3] = '{4, 4, 3};
  int mx  [3] = '{255, 3, 255};
  int mcnt [3][4];
  int mprev[3][4];
  int e_ack[3], e_data[3], e_sat[3], e_pulse[3], e_irq[3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        mcnt[d][i]  = 0;
        mprev[d][i] = 0;
      end
      e_ack[d] = 0; e_data[d] = 0; e_sat[d] = 0; e_pulse[d] = 0; e_irq[d] = 0;
    end
  endtask

  task automatic model_step();
    int rise [4];
    int sel;
    if (rst) begin
      model_reset();
      return;
    end
    sel = int'(rd_sel);
    for (int d = 0; d < 3; d++) begin
      e_pulse[d] = 0;
      e_irq[d]   = 0;
      for (int i = 0; i < wid[d]; i++) begin
        rise[i] = (evt[i] && mprev[d][i] == 0) ? 1 : 0;
        e_pulse[d] += rise[i] << i;
        if (mcnt[d][i] == mx[d]) e_irq[d] = 1;
      end
      e_ack[d] = rd_req ? 1 : 0;
      if (rd_req) begin
        if (sel < wid[d]) begin
          e_data[d] = mcnt[d][sel];
          e_sat[d]  = (mcnt[d][sel] == mx[d]) ? 1 : 0;
        end else begin
          e_data[d] = 0;
          e_sat[d]  = 0;
        end
      end
      for (int i = 0; i < wid[d]; i++) begin
        if (rd_req && rd_clr && sel == i) mcnt[d][i] = rise[i];
        else if (rise[i] == 1 && mcnt[d][i] < mx[d]) mcnt[d][i] = mcnt[d][i] + 1;
        mprev[d][i] = evt[i] ? 1 : 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0_ack", 32'(d0_ack), e_ack[0]);
    chk("d0_data", 32'(d0_data), e_data[0]);
    chk("d0_sat", 32'(d0_sat), e_sat[0]);
    chk("d0_pulse", 32'(d0_pulse), e_pulse[0]);
    chk("d0_irq", 32'(d0_irq), e_irq[0]);
    chk("d1_ack", 32'(d1_ack), e_ack[1]);
    chk("d1_data", 32'(d1_data), e_data[1]);
    chk("d1_sat", 32'(d1_sat), e_sat[1]);
    chk("d1_pulse", 32'(d1_pulse), e_pulse[1]);
    chk("d1_irq", 32'(d1_irq), e_irq[1]);
    chk("d2_ack", 32'(d2_ack), e_ack[2]);
    chk("d2_data", 32'(d2_data), e_data[2]);
    chk("d2_sat", 32'(d2_sat), e_sat[2]);
    chk("d2_pulse", 32'(d2_pulse), e_pulse[2]);
    chk("d2_irq", 32'(d2_irq), e_irq[2]);
  endtask

  task automatic cycle();
    @(posedge s_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic edges(input int bitn, input int n);
    for (int k = 0; k < n; k++) begin
      evt[bitn] = 1'b1; cycle();
      evt[bitn] = 1'b0; cycle();
    end
  endtask

  initial begin
    model_reset();

    // Reset state
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_ack", 32'(d0_ack), 0);
    chk("rst_data", 32'(d0_data), 0);
    chk("rst_irq", 32'(d1_irq), 0);
    rst = 1'b0;

    // Three toggles on bit 2, then read-with-clear of counter 2
    for (int k = 0; k < 3; k++) begin
      evt = 4'b0100; cycle();
      chk("pulse2_hi", 32'(d0_pulse), 32'h4);
      evt = 4'b0000; cycle();
      chk("pulse2_lo", 32'(d0_pulse), 0);
    end
    rd_req = 1'b1; rd_sel = 2'd2; rd_clr = 1'b1; cycle();
    chk("rd2_ack", 32'(d0_ack), 1);
    chk("rd2_data", 32'(d0_data), 3);
    chk("rd2_sat", 32'(d0_sat), 0);
    rd_req = 1'b0; rd_clr = 1'b0; cycle();
    chk("ack_one_cycle", 32'(d0_ack), 0);
    chk("data_hold", 32'(d0_data), 3);

    // Five edges on bit 0: 2-bit counter saturates, irq, then clear
    for (int k = 0; k < 5; k++) begin
      evt[0] = 1'b1; cycle();
      if (k == 2) chk("irq_not_yet", 32'(d1_irq), 0);
      evt[0] = 1'b0; cycle();
      if (k == 2) chk("irq_after_sat", 32'(d1_irq), 1);
    end
    rd_req = 1'b1; rd_sel = 2'd0; rd_clr = 1'b1; cycle();
    chk("sat_rd_data", 32'(d1_data), 3);
    chk("sat_rd_sat", 32'(d1_sat), 1);
    chk("irq_n1", 32'(d1_irq), 1);
    rd_req = 1'b0; rd_clr = 1'b0; cycle();
    chk("irq_n2", 32'(d1_irq), 0);
    chk("d0_cnt5", 32'(d0_data), 5);

    // Clear coinciding with a rising edge on bit 1
    edges(1, 5);
    evt = 4'b0010; rd_req = 1'b1; rd_sel = 2'd1; rd_clr = 1'b1; cycle();
    chk("clr_rise_data", 32'(d0_data), 5);
    evt = 4'b0000; rd_clr = 1'b0; cycle();
    chk("clr_rise_follow", 32'(d0_data), 1);
    rd_req = 1'b0; cycle();

    // Back-to-back reads, one per counter
    edges(3, 2);
    for (int s = 0; s < 4; s++) begin
      rd_req = 1'b1; rd_sel = 2'(s); cycle();
      chk("b2b_ack", 32'(d0_ack), 1);
    end
    rd_req = 1'b0; cycle();

    // Out-of-range select on the 3-bit instance
    rd_req = 1'b1; rd_sel = 2'd3; rd_clr = 1'b1; cycle();
    chk("oor_ack", 32'(d2_ack), 1);
    chk("oor_data", 32'(d2_data), 0);
    chk("oor_sat", 32'(d2_sat), 0);
    rd_req = 1'b0; rd_clr = 1'b0; cycle();

    // Reset the cycle after a read, with all events high
    evt = 4'b1111; rd_req = 1'b1; rd_sel = 2'd0; cycle();
    rst = 1'b1; rd_req = 1'b0; cycle();
    chk("rst_mid_ack", 32'(d0_ack), 0);
    chk("rst_mid_data", 32'(d0_data), 0);
    chk("rst_mid_pulse", 32'(d0_pulse), 0);
    rst = 1'b0; cycle();
    chk("post_rst_pulse", 32'(d0_pulse), 32'hf);
    for (int s = 0; s < 4; s++) begin
      rd_req = 1'b1; rd_sel = 2'(s); cycle();
      chk("post_rst_cnt", 32'(d0_data), 1);
    end
    rd_req = 1'b0; cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      evt    = 4'($urandom);
      rd_req = ($urandom_range(0, 2) == 0);
      rd_sel = 2'($urandom);
      rd_clr = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
